// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared types, constants and address-slicing helpers for the 2-way
// set-associative write-back cache controller.
//   - state_e : controller FSM states
//   - line_t  : one cache line {valid, dirty, tag, data}
//   - addr_*  : field extraction from a WORD address (byte offset dropped)
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W        = 10;                      // byte address width
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int NUM_SETS      = 2;
  localparam int NUM_WAYS      = 2;
  localparam int OFF_W         = $clog2(WORDS_PER_BLK);   // word offset bits
  localparam int IDX_W         = $clog2(NUM_SETS);
  localparam int TAG_W         = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int MADDR_W       = ADDR_W - 2;              // word address width

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  typedef struct packed {
    logic                            valid;
    logic                            dirty;
    logic [TAG_W-1:0]                tag;
    logic [WORDS_PER_BLK*WORD_W-1:0] data;
  } line_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [MADDR_W-1:0] waddr);
    return waddr[MADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [MADDR_W-1:0] waddr);
    return waddr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [MADDR_W-1:0] waddr);
    return waddr[OFF_W-1:0];
  endfunction

  // Flat line index: lines of one set sit next to each other.
  function automatic logic [IDX_W:0] line_sel(input logic [IDX_W-1:0] idx, input logic way);
    return {idx, way};
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input line_t line, input logic [OFF_W-1:0] off);
    return line.data[int'(off)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_ctrl_2way_if.sv
// ---------------------------------------------------------------------------
// cache_ctrl_2way_if
// Bundles the CPU request/response port and the word-wide memory beat port.
//   modport slave  : the cache controller (serves CPU, issues memory beats)
//   modport master : the environment (CPU requester + main memory)
// CPU side : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_ready, cpu_rdata, cpu_hit
// Mem side : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ready
// ---------------------------------------------------------------------------
interface cache_ctrl_2way_if;
  import cache_pkg::*;

  logic                cpu_req;
  logic                cpu_we;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [WORD_W-1:0]   cpu_wdata;
  logic                cpu_ready;
  logic [WORD_W-1:0]   cpu_rdata;
  logic                cpu_hit;

  logic                mem_req;
  logic                mem_we;
  logic [MADDR_W-1:0]  mem_addr;
  logic [WORD_W-1:0]   mem_wdata;
  logic [WORD_W-1:0]   mem_rdata;
  logic                mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_burst_ctr.sv
// ---------------------------------------------------------------------------
// cache_burst_ctr
// Beat counter for one memory burst.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (controller not bursting)
//   en         : a beat is being requested this cycle
//   mem_ready  : the current beat is accepted; advance
//   beat       : current beat number
//   last       : current beat is the final beat of the burst
// The counter wraps to 0 after the last beat, so a write-back burst can be
// followed directly by the refill burst without a gap cycle.
// ---------------------------------------------------------------------------
module cache_burst_ctr
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             mem_ready,
  output logic [OFF_W-1:0] beat,
  output logic             last
);

  logic [OFF_W-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr) begin
      beat_d = '0;
    end else if (en && mem_ready) begin
      beat_d = beat_q + OFF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;
  assign last = (beat_q == OFF_W'(WORDS_PER_BLK - 1));

endmodule

// File: rtl/cache_ctrl_2way.sv
// ---------------------------------------------------------------------------
// cache_ctrl_2way
// 2-way set-associative, write-back, write-allocate cache controller with
// LRU replacement and 4-beat word bursts to main memory.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : cache_ctrl_2way_if.slave (CPU port + memory beat port)
//   hit_cnt,
//   miss_cnt   : saturating request counters, present only when the macro
//                CACHE_STATS_EN is defined
// All bus outputs are decoded from registered state, so they drop on the
// same edge a reset is applied.
// ---------------------------------------------------------------------------
module cache_ctrl_2way
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cache_ctrl_2way_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);

  localparam int NUM_LINES = NUM_SETS * NUM_WAYS;

  state_e               state_q, state_d;
  logic [MADDR_W-1:0]   req_waddr_q, req_waddr_d;
  logic                 req_we_q, req_we_d;
  logic [WORD_W-1:0]    req_wdata_q, req_wdata_d;
  logic                 miss_q, miss_d;
  logic                 victim_q, victim_d;
  logic [NUM_SETS-1:0]  lru_q, lru_d;      // lru_q[set] names the way to evict next
  line_t                lines_q [NUM_LINES];
  line_t                lines_d [NUM_LINES];

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [OFF_W-1:0]     req_off;
  logic [NUM_WAYS-1:0]  way_hit;
  logic [NUM_WAYS-1:0]  way_valid;
  logic                 hit;
  logic                 hit_way;
  logic                 pick_way;
  line_t                hit_line;
  line_t                vic_line;

  logic [OFF_W-1:0]     beat;
  logic                 beat_last;
  logic                 ctr_clr;

  logic                 cpu_ready, cpu_hit, mem_req, mem_we;
  logic [WORD_W-1:0]    cpu_rdata, mem_wdata;
  logic [MADDR_W-1:0]   mem_addr;

  assign req_tag = addr_tag(req_waddr_q);
  assign req_idx = addr_idx(req_waddr_q);
  assign req_off = addr_off(req_waddr_q);

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    line_t way_line;
    assign way_line      = lines_q[line_sel(req_idx, 1'(gi))];
    assign way_valid[gi] = way_line.valid;
    assign way_hit[gi]   = way_line.valid && (way_line.tag == req_tag);
  end

  // A tag can live in at most one way, so the upper hit bit is the hit way.
  assign hit      = |way_hit;
  assign hit_way  = way_hit[1];
  // Fill empty ways first (way0 before way1), then fall back to LRU.
  assign pick_way = !way_valid[0] ? 1'b0 :
                    !way_valid[1] ? 1'b1 : lru_q[req_idx];
  assign hit_line = lines_q[line_sel(req_idx, hit_way)];
  assign vic_line = lines_q[line_sel(req_idx, victim_q)];

  cache_burst_ctr u_burst_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (ctr_clr),
    .en        (mem_req),
    .mem_ready (bus.mem_ready),
    .beat      (beat),
    .last      (beat_last)
  );

  always_comb begin
    state_d     = state_q;
    req_waddr_d = req_waddr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    miss_d      = miss_q;
    victim_d    = victim_q;
    lru_d       = lru_q;
    lines_d     = lines_q;
    cpu_ready   = 1'b0;
    cpu_hit     = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ctr_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ctr_clr = 1'b1;
        if (bus.cpu_req) begin
          req_waddr_d = bus.cpu_addr[ADDR_W-1:2];
          req_we_d    = bus.cpu_we;
          req_wdata_d = bus.cpu_wdata;
          miss_d      = 1'b0;
          state_d     = COMPARE;
        end
      end

      COMPARE: begin
        ctr_clr = 1'b1;
        if (hit) begin
          cpu_ready = 1'b1;
          cpu_hit   = !miss_q;
          if (req_we_q) begin
            lines_d[line_sel(req_idx, hit_way)].data[int'(req_off)*WORD_W +: WORD_W] = req_wdata_q;
            lines_d[line_sel(req_idx, hit_way)].dirty = 1'b1;
          end else begin
            cpu_rdata = line_word(hit_line, req_off);
          end
          lru_d[req_idx] = !hit_way;
          state_d        = IDLE;
        end else begin
          miss_d   = 1'b1;
          victim_d = pick_way;
          if (lines_q[line_sel(req_idx, pick_way)].valid &&
              lines_q[line_sel(req_idx, pick_way)].dirty) begin
            state_d = WRITEBACK;
          end else begin
            // The line is about to be overwritten word by word; it must not
            // look valid under its old tag while the refill is in flight.
            lines_d[line_sel(req_idx, pick_way)].valid = 1'b0;
            state_d = ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_line.tag, req_idx, beat};
        mem_wdata = line_word(vic_line, beat);
        if (bus.mem_ready && beat_last) begin
          lines_d[line_sel(req_idx, victim_q)].dirty = 1'b0;
          lines_d[line_sel(req_idx, victim_q)].valid = 1'b0;
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat};
        if (bus.mem_ready) begin
          lines_d[line_sel(req_idx, victim_q)].data[int'(beat)*WORD_W +: WORD_W] = bus.mem_rdata;
          if (beat_last) begin
            lines_d[line_sel(req_idx, victim_q)].valid = 1'b1;
            lines_d[line_sel(req_idx, victim_q)].dirty = 1'b0;
            lines_d[line_sel(req_idx, victim_q)].tag   = req_tag;
            state_d = COMPARE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_waddr_q <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      miss_q      <= 1'b0;
      victim_q    <= 1'b0;
      lru_q       <= '0;
      // Tags and data are left as they are; only the status bits matter.
      for (int i = 0; i < NUM_LINES; i++) begin
        lines_q[i].valid <= 1'b0;
        lines_q[i].dirty <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      req_waddr_q <= req_waddr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      miss_q      <= miss_d;
      victim_q    <= victim_d;
      lru_q       <= lru_d;
      lines_q     <= lines_d;
    end
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_hit   = cpu_hit;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cpu_ready) begin
      if (cpu_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
